// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state
// encoding, opcode/funct constants, ALU operation codes and the datapath
// mux select codes. Imported by the controller, its ALU decoder, the
// datapath and the testbench so every block agrees on one encoding.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Controller-to-ALU-decoder operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder for the multicycle controller. Purely combinational.
// Ports:
//   funct_i      - instr[5:0], only consulted when aluop_i selects funct decode
//   aluop_i      - operation class from the FSM (ADD, SUB or funct decode)
//   alucontrol_o - ALU operation code
//   bad_funct_o  - funct decode requested but funct is not supported
module mc_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [1:0] aluop_i,
  output logic [3:0] alucontrol_o,
  output logic       bad_funct_o
);

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    unique case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      default: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_NOR:  alucontrol_o = ALU_NOR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          // Unknown funct still executes as ADD; it is only flagged.
          default: bad_funct_o  = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multicycle MIPS datapath. Steps the
// shared-ALU, single-memory datapath through fetch/decode/execute/memory/
// writeback and drives every mux select and write enable.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   op, funct, zero   - opcode/funct from the IR, ALU zero flag
//   iord .. pcsrc     - datapath mux selects and write enables
//   alucontrol        - ALU operation (ALUCW bits)
//   illegal           - one-cycle pulse on unsupported opcode or funct
//   state             - current state for debug
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [ALUCW-1:0] alucontrol,
  output logic             illegal,
  output logic [3:0]       state
);

  state_e state_q, state_d;
  state_e out_st;           // state seen by the output decode
  logic   pcwrite, branch, bad_op, bad_funct;
  logic   irwrite_raw, regwrite_raw, memwrite_raw;
  logic [1:0] aluop;
  logic [3:0] alu_code;

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples its input on the same edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // While reset is high the outputs already show FETCH values, even before
  // the first edge has cleared the state register.
  assign out_st = reset ? ST_FETCH : state_q;
  assign state  = out_st;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   state_d = ST_MEMWB;
      ST_EXECUTE: state_d = ST_ALUWB;
      ST_ADDIEX:  state_d = ST_ADDIWB;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_B;
    pcsrc        = PCSRC_ALURES;
    aluop        = ALUOP_ADD;
    bad_op       = 1'b0;
    unique case (out_st)
      ST_FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = SRCB_FOUR;
      end
      ST_DECODE: begin
        alusrcb = SRCB_IMMSH;
        bad_op  = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
      end
      ST_MEMADR, ST_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ST_MEMRD: iord = 1'b1;
      ST_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      ST_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      ST_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      ST_BRANCH: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
        aluop   = ALUOP_SUB;
      end
      ST_ADDIWB: regwrite_raw = 1'b1;
      ST_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .funct_i      (funct),
    .aluop_i      (aluop),
    .alucontrol_o (alu_code),
    .bad_funct_o  (bad_funct)
  );

  assign alucontrol = ALUCW'(alu_code);

  // Write enables and the illegal pulse are suppressed during reset so an
  // aborted instruction cannot commit anything in the reset cycle.
  assign irwrite  = irwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign illegal  = (bad_op | ((out_st == ST_EXECUTE) & bad_funct)) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. An instruction-level model
// expands each opcode into its list of phases and derives the expected
// control word of every phase from the per-state signal table.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alu;
    logic       illegal;
  } ctrl_t;

  int seq[$];

  multicycle_controller #(.ALUCW(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic legal_op(input logic [5:0] o);
    return o == OP_LW || o == OP_SW || o == OP_RTYPE || o == OP_BEQ ||
           o == OP_ADDI || o == OP_J;
  endfunction

  function automatic logic [4:0] funct_lookup(input logic [5:0] f);
    // {bad, code}
    case (f)
      FN_ADD:  return {1'b0, ALU_ADD};
      FN_SUB:  return {1'b0, ALU_SUB};
      FN_AND:  return {1'b0, ALU_AND};
      FN_OR:   return {1'b0, ALU_OR};
      FN_NOR:  return {1'b0, ALU_NOR};
      FN_SLT:  return {1'b0, ALU_SLT};
      default: return {1'b1, ALU_ADD};
    endcase
  endfunction

  // Phase lists per instruction, counted from FETCH.
  task automatic build_seq(input logic [5:0] o);
    case (o)
      OP_LW:    seq = '{0, 1, 2, 3, 4};
      OP_SW:    seq = '{0, 1, 2, 5};
      OP_RTYPE: seq = '{0, 1, 6, 7};
      OP_BEQ:   seq = '{0, 1, 8};
      OP_ADDI:  seq = '{0, 1, 9, 10};
      OP_J:     seq = '{0, 1, 11};
      default:  seq = '{0, 1};
    endcase
  endtask

  function automatic ctrl_t model_ctrl(input int st, input logic [5:0] o,
                                       input logic [5:0] f, input logic z);
    ctrl_t c;
    logic pcw, br;
    logic [4:0] fl;
    c = '0; c.alu = ALU_ADD; pcw = 1'b0; br = 1'b0;
    case (st)
      0:  begin c.irwrite = 1'b1; pcw = 1'b1; c.alusrcb = SRCB_FOUR; end
      1:  begin c.alusrcb = SRCB_IMMSH; c.illegal = !legal_op(o); end
      2, 9: begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      3:  c.iord = 1'b1;
      4:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      6:  begin
            fl = funct_lookup(f);
            c.alusrca = 1'b1; c.alu = fl[3:0]; c.illegal = fl[4];
          end
      7:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      8:  begin c.alusrca = 1'b1; br = 1'b1; c.pcsrc = PCSRC_ALUOUT; c.alu = ALU_SUB; end
      10: c.regwrite = 1'b1;
      11: begin pcw = 1'b1; c.pcsrc = PCSRC_JUMP; end
      default: ;
    endcase
    c.pcen = pcw | (br & z);
    return c;
  endfunction

  function automatic ctrl_t observed();
    return {iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca,
            alusrcb, pcsrc, alucontrol, illegal};
  endfunction

  // Runs one instruction (or its first max_cyc phases when max_cyc >= 0).
  // zmode: 0 -> zero=0, 1 -> zero=1, 2 -> random each cycle.
  // Entered and left just after a rising edge.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int max_cyc);
    int n;
    ctrl_t exp;
    build_seq(o);
    n = (max_cyc >= 0 && max_cyc < seq.size()) ? max_cyc : seq.size();
    for (int i = 0; i < n; i++) begin
      op    = o;
      funct = f;
      zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      exp = model_ctrl(seq[i], o, f, zero);
      check({name, " state"}, 32'(state), 32'(seq[i]));
      check({name, " ctrl"}, 32'(observed()), 32'(exp));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_cycles(input int n);
    ctrl_t exp;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = model_ctrl(0, op, funct, zero);
      exp.irwrite = 1'b0;
      exp.pcen    = 1'b0;
      check("reset state", 32'(state), 32'd0);
      check("reset ctrl", 32'(observed()), 32'(exp));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  logic [5:0] op_tab [6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
  logic [5:0] fn_tab [6] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};

  initial begin
    logic [31:0] r;
    logic [5:0]  ro, rf;
    op = OP_SW; funct = FN_ADD; zero = 1'b0;
    reset_cycles(2);

    // Reset mid-MEMWR: run sw to MEMWR, then hold reset three cycles.
    run_instr("sw_pre", OP_SW, FN_ADD, 2, 3);
    reset_cycles(3);

    run_instr("lw", OP_LW, FN_ADD, 2, -1);
    run_instr("sw", OP_SW, FN_ADD, 2, -1);
    for (int i = 0; i < 6; i++) run_instr("rtype", OP_RTYPE, fn_tab[i], 2, -1);
    run_instr("rtype_bad", OP_RTYPE, 6'b111111, 2, -1);
    run_instr("beq_taken", OP_BEQ, FN_ADD, 1, -1);
    run_instr("beq_not", OP_BEQ, FN_ADD, 0, -1);
    run_instr("j", OP_J, FN_ADD, 2, -1);
    run_instr("illegal_op", 6'b111111, FN_ADD, 2, -1);

    for (int k = 0; k < 300; k++) begin
      r = $urandom();
      ro = r[5:0];
      rf = r[11:6];
      if (r[14:12] < 3'd6) ro = op_tab[r[14:12]];
      if (r[15]) rf = fn_tab[r[18:16] % 6];
      if (r[23:19] == 5'd0) begin
        run_instr("rand_abort", ro, rf, 2, int'(r[26:24] % 4));
        reset_cycles(1 + int'(r[28:27]));
      end else begin
        run_instr("rand", ro, rf, 2, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
